// File: rtl/gfg_pkg.sv
// Shared definitions for the triangle list scheduler.
//   - register-bank map (control word, triangle records)
//   - bit offsets / widths of every register field
//   - scheduler state enumeration
//   - field extraction helper
package gfg_pkg;

   // Register map
   localparam int unsigned CTRL_ADDR     = 0;
   localparam int unsigned TRI_BASE      = 1;
   localparam int unsigned TRI_STRIDE    = 2;

   // Control word fields
   localparam int unsigned CTRL_EN_BIT   = 31;
   localparam int unsigned CTRL_CNT_OFF  = 0;
   localparam int unsigned CTRL_CNT_W    = 3;

   // Triangle record fields. The "lo" pair is (x0,y0) in the first word
   // and (x2,y2) in the second; the "hi" pair is (x1,y1) in the first word.
   localparam int unsigned X_LO_OFF      = 0;
   localparam int unsigned Y_LO_OFF      = 8;
   localparam int unsigned X_HI_OFF      = 16;
   localparam int unsigned Y_HI_OFF      = 24;
   localparam int unsigned X_FIELD_W     = 7;
   localparam int unsigned Y_FIELD_W     = 6;
   localparam int unsigned COLOR_OFF     = 16;
   localparam int unsigned COLOR_FIELD_W = 12;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_CTRL,
      ST_LAT_CTRL,
      ST_RD_A,
      ST_LAT_A,
      ST_RD_B,
      ST_LAT_B,
      ST_LAUNCH,
      ST_GUARD,
      ST_WAIT_DONE,
      ST_FINISH
   } state_t;

   // Returns the field of 'width' bits at 'off', zero-extended to 32 bits.
   function automatic logic [31:0] get_field(input logic [31:0] w,
                                             input int unsigned off,
                                             input int unsigned width);
      get_field = (w >> off) & ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/tri_reg_unpack.sv
// Combinational decode of one triangle-record register word.
// Each coordinate field is truncated to the coordinate port width and then
// clamped to the last valid pixel/line.
//   rdata  in   32-bit register word
//   x_lo   out  x field at X_LO_OFF (x0 or x2), clamped
//   y_lo   out  y field at Y_LO_OFF (y0 or y2), clamped
//   x_hi   out  x field at X_HI_OFF (x1), clamped
//   y_hi   out  y field at Y_HI_OFF (y1), clamped
//   color  out  colour field (second word only)
module tri_reg_unpack
   import gfg_pkg::*;
#(
   parameter int unsigned HORIZ_RESOLUTION = 80,
   parameter int unsigned VERT_RESOLUTION  = 60,
   parameter int unsigned COLOR_DEPTH      = 12,
   localparam int unsigned XW = $clog2(HORIZ_RESOLUTION),
   localparam int unsigned YW = $clog2(VERT_RESOLUTION)
) (
   input  logic [31:0]            rdata,
   output logic [XW-1:0]          x_lo,
   output logic [YW-1:0]          y_lo,
   output logic [XW-1:0]          x_hi,
   output logic [YW-1:0]          y_hi,
   output logic [COLOR_DEPTH-1:0] color
);

   function automatic logic [XW-1:0] clamp_x(input logic [31:0] f);
      logic [XW-1:0] t;
      t = f[XW-1:0];
      clamp_x = (32'(t) >= HORIZ_RESOLUTION) ? XW'(HORIZ_RESOLUTION - 1) : t;
   endfunction

   function automatic logic [YW-1:0] clamp_y(input logic [31:0] f);
      logic [YW-1:0] t;
      t = f[YW-1:0];
      clamp_y = (32'(t) >= VERT_RESOLUTION) ? YW'(VERT_RESOLUTION - 1) : t;
   endfunction

   always_comb begin
      x_lo  = clamp_x(get_field(rdata, X_LO_OFF, X_FIELD_W));
      y_lo  = clamp_y(get_field(rdata, Y_LO_OFF, Y_FIELD_W));
      x_hi  = clamp_x(get_field(rdata, X_HI_OFF, X_FIELD_W));
      y_hi  = clamp_y(get_field(rdata, Y_HI_OFF, Y_FIELD_W));
      color = COLOR_DEPTH'(get_field(rdata, COLOR_OFF, COLOR_FIELD_W));
   end

endmodule

// File: rtl/triangle_list_scheduler.sv
// Per-frame triangle list sequencer.
// On i_new_frame it reads the control word and the triangle records from
// the register bank, launches the rasterizer once per triangle and waits
// for it to finish before moving on.
//   i_clk, srst_n          clock, synchronous active-low reset
//   i_new_frame            frame start pulse from the swapping controller
//   o_reg_addr/i_reg_rdata register bank read port (1-cycle read latency)
//   o_go                   rasterizer start pulse
//   o_p*_x/o_p*_y/o_color  triangle presented to the rasterizer
//   i_raster_done          rasterizer idle/done level
//   o_raster_in_progress   high while the list is being drawn
//   o_frame_done           pulse when the list completes
//   o_overrun              sticky: frame start seen while busy
//   o_frame_count          completed frames, modulo 2^16
module triangle_list_scheduler
   import gfg_pkg::*;
#(
   parameter int unsigned HORIZ_RESOLUTION = 80,
   parameter int unsigned VERT_RESOLUTION  = 60,
   parameter int unsigned MAX_TRIANGLES    = 7,
   parameter int unsigned COLOR_DEPTH      = 12,
   localparam int unsigned XW = $clog2(HORIZ_RESOLUTION),
   localparam int unsigned YW = $clog2(VERT_RESOLUTION)
) (
   input  logic                   i_clk,
   input  logic                   srst_n,
   input  logic                   i_new_frame,
   output logic [3:0]             o_reg_addr,
   input  logic [31:0]            i_reg_rdata,
   output logic                   o_go,
   output logic [XW-1:0]          o_p0_x,
   output logic [YW-1:0]          o_p0_y,
   output logic [XW-1:0]          o_p1_x,
   output logic [YW-1:0]          o_p1_y,
   output logic [XW-1:0]          o_p2_x,
   output logic [YW-1:0]          o_p2_y,
   output logic [COLOR_DEPTH-1:0] o_color,
   input  logic                   i_raster_done,
   output logic                   o_raster_in_progress,
   output logic                   o_frame_done,
   output logic                   o_overrun,
   output logic [15:0]            o_frame_count
);

   state_t                  state;
   logic [CTRL_CNT_W-1:0]   idx;
   logic [CTRL_CNT_W-1:0]   eff_cnt;
   logic [CTRL_CNT_W-1:0]   idx_next;

   logic                    ctrl_en;
   logic [CTRL_CNT_W-1:0]   ctrl_cnt;
   logic [CTRL_CNT_W-1:0]   ctrl_eff;

   logic [XW-1:0]           ux_lo;
   logic [YW-1:0]           uy_lo;
   logic [XW-1:0]           ux_hi;
   logic [YW-1:0]           uy_hi;
   logic [COLOR_DEPTH-1:0]  ucolor;

   tri_reg_unpack #(
      .HORIZ_RESOLUTION (HORIZ_RESOLUTION),
      .VERT_RESOLUTION  (VERT_RESOLUTION),
      .COLOR_DEPTH      (COLOR_DEPTH)
   ) u_unpack (
      .rdata (i_reg_rdata),
      .x_lo  (ux_lo),
      .y_lo  (uy_lo),
      .x_hi  (ux_hi),
      .y_hi  (uy_hi),
      .color (ucolor)
   );

   function automatic logic [3:0] tri_addr(input logic [CTRL_CNT_W-1:0] k);
      tri_addr = 4'(TRI_BASE + TRI_STRIDE * 32'(k));
   endfunction

   always_comb begin
      ctrl_en  = i_reg_rdata[CTRL_EN_BIT];
      ctrl_cnt = CTRL_CNT_W'(get_field(i_reg_rdata, CTRL_CNT_OFF, CTRL_CNT_W));
      ctrl_eff = (32'(ctrl_cnt) > MAX_TRIANGLES) ? CTRL_CNT_W'(MAX_TRIANGLES)
                                                 : ctrl_cnt;
      idx_next = idx + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!srst_n) begin
         state                <= ST_IDLE;
         idx                  <= '0;
         eff_cnt              <= '0;
         o_reg_addr           <= '0;
         o_go                 <= 1'b0;
         o_p0_x               <= '0;
         o_p0_y               <= '0;
         o_p1_x               <= '0;
         o_p1_y               <= '0;
         o_p2_x               <= '0;
         o_p2_y               <= '0;
         o_color              <= '0;
         o_raster_in_progress <= 1'b0;
         o_frame_done         <= 1'b0;
         o_overrun            <= 1'b0;
         o_frame_count        <= '0;
      end else begin
         o_go         <= 1'b0;
         o_frame_done <= 1'b0;

         // Any frame start outside IDLE (FINISH included) is dropped.
         if (i_new_frame && (state != ST_IDLE))
            o_overrun <= 1'b1;

         case (state)
            ST_IDLE: begin
               o_reg_addr <= 4'(CTRL_ADDR);
               if (i_new_frame) begin
                  state                <= ST_RD_CTRL;
                  o_raster_in_progress <= 1'b1;
               end
            end

            ST_RD_CTRL: state <= ST_LAT_CTRL;

            ST_LAT_CTRL: begin
               eff_cnt <= ctrl_eff;
               idx     <= '0;
               if (!ctrl_en || (ctrl_eff == '0)) begin
                  state                <= ST_FINISH;
                  o_frame_done         <= 1'b1;
                  o_frame_count        <= o_frame_count + 16'd1;
                  o_raster_in_progress <= 1'b0;
               end else begin
                  state      <= ST_RD_A;
                  o_reg_addr <= tri_addr('0);
               end
            end

            ST_RD_A: state <= ST_LAT_A;

            ST_LAT_A: begin
               o_p0_x     <= ux_lo;
               o_p0_y     <= uy_lo;
               o_p1_x     <= ux_hi;
               o_p1_y     <= uy_hi;
               o_reg_addr <= o_reg_addr + 4'd1;
               state      <= ST_RD_B;
            end

            ST_RD_B: state <= ST_LAT_B;

            ST_LAT_B: begin
               o_p2_x  <= ux_lo;
               o_p2_y  <= uy_lo;
               o_color <= ucolor;
               o_go    <= 1'b1;
               state   <= ST_LAUNCH;
            end

            ST_LAUNCH: state <= ST_GUARD;

            // The rasterizer may still show its previous done level here.
            ST_GUARD: state <= ST_WAIT_DONE;

            ST_WAIT_DONE: begin
               if (i_raster_done) begin
                  idx <= idx_next;
                  if (idx_next < eff_cnt) begin
                     state      <= ST_RD_A;
                     o_reg_addr <= tri_addr(idx_next);
                  end else begin
                     state                <= ST_FINISH;
                     o_frame_done         <= 1'b1;
                     o_frame_count        <= o_frame_count + 16'd1;
                     o_raster_in_progress <= 1'b0;
                  end
               end
            end

            ST_FINISH: begin
               state      <= ST_IDLE;
               o_reg_addr <= 4'(CTRL_ADDR);
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_triangle_list_scheduler.sv
// Scoreboard bench for triangle_list_scheduler (MAX_TRIANGLES = 5).
module tb_triangle_list_scheduler;

   localparam int MAXT = 5;

   logic        i_clk;
   logic        srst_n;
   logic        i_new_frame;
   logic [3:0]  o_reg_addr;
   logic [31:0] i_reg_rdata;
   logic        o_go;
   logic [6:0]  o_p0_x, o_p1_x, o_p2_x;
   logic [5:0]  o_p0_y, o_p1_y, o_p2_y;
   logic [11:0] o_color;
   logic        i_raster_done;
   logic        o_raster_in_progress;
   logic        o_frame_done;
   logic        o_overrun;
   logic [15:0] o_frame_count;

   triangle_list_scheduler #(
      .HORIZ_RESOLUTION (80),
      .VERT_RESOLUTION  (60),
      .MAX_TRIANGLES    (MAXT),
      .COLOR_DEPTH      (12)
   ) dut (
      .i_clk                (i_clk),
      .srst_n               (srst_n),
      .i_new_frame          (i_new_frame),
      .o_reg_addr           (o_reg_addr),
      .i_reg_rdata          (i_reg_rdata),
      .o_go                 (o_go),
      .o_p0_x               (o_p0_x),
      .o_p0_y               (o_p0_y),
      .o_p1_x               (o_p1_x),
      .o_p1_y               (o_p1_y),
      .o_p2_x               (o_p2_x),
      .o_p2_y               (o_p2_y),
      .o_color              (o_color),
      .i_raster_done        (i_raster_done),
      .o_raster_in_progress (o_raster_in_progress),
      .o_frame_done         (o_frame_done),
      .o_overrun            (o_overrun),
      .o_frame_count        (o_frame_count)
   );

   typedef struct {
      logic [50:0] tri_bits;
      bit          first;
   } exp_tri_t;

   typedef struct {
      logic [15:0] count;
      bit          empty;
   } exp_frame_t;

   exp_tri_t    exp_tri_q[$];
   exp_frame_t  exp_frame_q[$];

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          nf_cycle = 0;
   int          last_done_cycle = 0;
   int          frames_seen = 0;
   int          ip_acc = 0;
   bit          ip_open = 0;
   bit          in_reset = 1;
   int          force_len = 0;
   int          busy_left = 0;
   int          go_wait = 0;
   logic [15:0] exp_fc = '0;

   logic [31:0] regs [16];
   int          tv [7][7];   // per triangle: x0 y0 x1 y1 x2 y2 colour

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int cx(input int v);
      return (v >= 80) ? 79 : v;
   endfunction

   function automatic int cy(input int v);
      return (v >= 60) ? 59 : v;
   endfunction

   function automatic logic [50:0] exp_pack(input int k);
      return {7'(cx(tv[k][0])), 6'(cy(tv[k][1])), 7'(cx(tv[k][2])), 6'(cy(tv[k][3])),
              7'(cx(tv[k][4])), 6'(cy(tv[k][5])), 12'(tv[k][6])};
   endfunction

   // Clock and cycle counter
   initial begin
      i_clk = 0;
      forever #5 i_clk = ~i_clk;
   end

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // Register bank port B: data for the address seen in one cycle
   // appears in the next.
   initial begin
      logic [3:0] a;
      i_reg_rdata = '0;
      forever begin
         @(negedge i_clk);
         a = o_reg_addr;
         @(posedge i_clk);
         #1;
         i_reg_rdata = regs[a];
      end
   end

   // Rasterizer: keeps done high for two more cycles after go, then low
   // for force_len cycles (random when 0), then high again.
   initial begin
      i_raster_done = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               i_raster_done = 1'b1;
               last_done_cycle = cyc;
            end
         end
         if (o_go) go_wait = 2;
         else if (go_wait > 0) begin
            go_wait--;
            if (go_wait == 0) begin
               i_raster_done = 1'b0;
               busy_left = (force_len > 0) ? force_len : int'($urandom_range(1, 12));
            end
         end
      end
   end

   // Monitor
   initial forever begin
      @(negedge i_clk);
      if (!in_reset && srst_n) begin
         if (o_go) begin
            chk("go_expected", 64'(exp_tri_q.size() > 0), 64'(1));
            if (exp_tri_q.size() > 0) begin
               exp_tri_t e;
               e = exp_tri_q.pop_front();
               chk("go_vertices",
                   64'({o_p0_x, o_p0_y, o_p1_x, o_p1_y, o_p2_x, o_p2_y, o_color}),
                   64'(e.tri_bits));
               chk("go_cycle", 64'(cyc), 64'(e.first ? nf_cycle + 7 : last_done_cycle + 5));
            end
            chk("go_while_done_high", 64'(i_raster_done), 64'(1));
         end
         if (o_frame_done) begin
            chk("frame_done_expected", 64'(exp_frame_q.size() > 0), 64'(1));
            if (exp_frame_q.size() > 0) begin
               exp_frame_t f;
               f = exp_frame_q.pop_front();
               chk("frame_count", 64'(o_frame_count), 64'(f.count));
               chk("frame_done_cycle", 64'(cyc), 64'(f.empty ? nf_cycle + 3 : last_done_cycle + 1));
            end
            frames_seen++;
            ip_open = 0;
         end
         chk("in_progress", 64'(o_raster_in_progress), 64'(ip_open && (cyc > ip_acc)));
      end
   end

   task automatic set_tri(input int k, input int x0, input int y0, input int x1,
                          input int y1, input int x2, input int y2, input int col);
      tv[k][0] = x0; tv[k][1] = y0; tv[k][2] = x1; tv[k][3] = y1;
      tv[k][4] = x2; tv[k][5] = y2; tv[k][6] = col;
   endtask

   task automatic rand_tris();
      for (int k = 0; k < 7; k++)
         set_tri(k, $urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 127),
                 $urandom_range(0, 63), $urandom_range(0, 127), $urandom_range(0, 63),
                 $urandom_range(0, 4095));
   endtask

   task automatic pulse_nf(input bit accept);
      @(posedge i_clk);
      #1;
      i_new_frame = 1'b1;
      if (accept) begin
         nf_cycle = cyc;
         ip_acc   = cyc;
         ip_open  = 1;
      end
      @(posedge i_clk);
      #1;
      i_new_frame = 1'b0;
   endtask

   // Programs the register bank, queues the expected responses and
   // starts the frame.
   task automatic launch_frame(input bit en, input int cnt, input int busy);
      int eff;
      eff = en ? ((cnt > MAXT) ? MAXT : cnt) : 0;
      regs[0] = {en, 28'($urandom), 3'(cnt)};
      for (int k = 0; k < 7; k++) begin
         regs[1 + 2 * k] = tv[k][0] + (tv[k][1] << 8) + (tv[k][2] << 16) + (tv[k][3] << 24);
         regs[2 + 2 * k] = tv[k][4] + (tv[k][5] << 8) + (tv[k][6] << 16);
      end
      force_len = busy;
      for (int k = 0; k < eff; k++) begin
         exp_tri_t e;
         e.tri_bits = exp_pack(k);
         e.first    = (k == 0);
         exp_tri_q.push_back(e);
      end
      begin
         exp_frame_t f;
         exp_fc  = exp_fc + 16'd1;
         f.count = exp_fc;
         f.empty = (eff == 0);
         exp_frame_q.push_back(f);
      end
      pulse_nf(1);
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (frames_seen < target && n < 3000) begin
         @(negedge i_clk);
         n++;
      end
      chk("frame_timeout", 64'(frames_seen >= target), 64'(1));
      repeat (2) @(negedge i_clk);
      chk("tri_queue_drained", 64'(exp_tri_q.size()), 64'(0));
   endtask

   task automatic run_frame(input bit en, input int cnt, input int busy);
      int target;
      target = frames_seen + 1;
      launch_frame(en, cnt, busy);
      wait_frames(target);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vertices"},
          64'({o_p0_x, o_p0_y, o_p1_x, o_p1_y, o_p2_x, o_p2_y, o_color}), 64'(0));
      chk({tag, "_ctrl"},
          64'({o_go, o_frame_done, o_overrun, o_raster_in_progress, o_reg_addr, o_frame_count}),
          64'(0));
   endtask

   initial begin
      int target;
      for (int a = 0; a < 16; a++) regs[a] = '0;
      for (int k = 0; k < 7; k++) set_tri(k, 0, 0, 0, 0, 0, 0, 0);
      srst_n      = 1'b0;
      i_new_frame = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_all_zero("reset_state");
      @(posedge i_clk);
      #1;
      srst_n   = 1'b1;
      in_reset = 0;
      repeat (3) @(posedge i_clk);

      // Single triangle, done held low for 20 cycles
      set_tri(0, 10, 10, 10, 50, 50, 25, 12'hF00);
      run_frame(1, 1, 20);
      chk("count_after_first", 64'(o_frame_count), 64'(1));

      // Three distinct triangles
      set_tri(0, 1, 2, 3, 4, 5, 6, 12'h123);
      set_tri(1, 70, 50, 20, 30, 40, 10, 12'h0F0);
      set_tri(2, 79, 59, 0, 0, 33, 44, 12'hABC);
      run_frame(1, 3, 0);

      // Disabled and empty lists
      run_frame(0, 3, 0);
      run_frame(1, 0, 0);

      // Count above capacity, coordinates above range
      rand_tris();
      for (int k = 0; k < 7; k++) begin
         tv[k][0] = 127;
         tv[k][1] = 63;
      end
      tv[1][2] = 80;
      tv[2][5] = 60;
      run_frame(1, 7, 0);
      chk("no_overrun_yet", 64'(o_overrun), 64'(0));

      // Second frame start while waiting for the rasterizer
      set_tri(0, 5, 5, 60, 5, 30, 40, 12'h00F);
      target = frames_seen + 1;
      launch_frame(1, 1, 30);
      repeat (9) @(posedge i_clk);
      pulse_nf(0);
      @(negedge i_clk);
      chk("overrun_set", 64'(o_overrun), 64'(1));
      wait_frames(target);
      repeat (20) @(negedge i_clk);
      chk("overrun_single_frame", 64'(frames_seen), 64'(target));
      chk("overrun_sticky", 64'(o_overrun), 64'(1));

      // Reset while waiting for the rasterizer
      rand_tris();
      launch_frame(1, 3, 15);
      repeat (10) @(posedge i_clk);
      #1;
      in_reset = 1;
      srst_n   = 1'b0;
      @(posedge i_clk);
      #1;
      srst_n = 1'b1;
      @(negedge i_clk);
      check_all_zero("mid_reset");
      exp_tri_q.delete();
      exp_frame_q.delete();
      exp_fc        = '0;
      ip_open       = 0;
      busy_left     = 0;
      go_wait       = 0;
      i_raster_done = 1'b1;
      in_reset      = 0;
      repeat (20) @(negedge i_clk);
      chk("no_done_after_reset", 64'(o_frame_count), 64'(0));
      rand_tris();
      run_frame(1, 2, 0);
      chk("count_after_reset", 64'(o_frame_count), 64'(1));

      // Random frames
      for (int f = 0; f < 8; f++) begin
         rand_tris();
         run_frame(($urandom_range(0, 5) != 0), $urandom_range(0, 7), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
